// File: rtl/fifo_buffer_ctrl_if.sv
// Request/response bundle between the request producer and the FIFO.
// The producer side uses the master modport; the FIFO uses the slave modport.
interface fifo_buffer_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 64
);
  localparam int AW = $clog2(DEPTH);

  logic              wren;
  logic [DATA_W-1:0] wrdata;
  logic              rden;
  logic [DATA_W-1:0] rddata;
  logic              rdvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wren, wrdata, rden,
    input  rddata, rdvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wren, wrdata, rden,
    output rddata, rdvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_buffer_ctrl.sv
// Synchronous FIFO with internal addressing, registered read data, occupancy
// counter, almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_buffer_ctrl #(
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input logic               memclk,
  input logic               rst,
  fifo_buffer_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic        AF_RST  = (AF_LEVEL == 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rdvalid_q, rdvalid_d;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic              wr_acc, rd_acc;

  // Simultaneous accepted read and write leave occupancy unchanged.
  function automatic logic [AW:0] next_count(input logic [AW:0] cnt,
                                             input logic wr, input logic rd);
    logic [AW:0] res;
    res = cnt;
    if (wr && !rd) res = cnt + (AW+1)'(1);
    if (rd && !wr) res = cnt - (AW+1)'(1);
    return res;
  endfunction

  always_comb begin
    // Acceptance looks only at start-of-cycle flags, so no fall-through.
    wr_acc         = bus.wren && !full_q;
    rd_acc         = bus.rden && !empty_q;
    wr_ptr_d       = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d        = next_count(count_q, wr_acc, rd_acc);
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
    overflow_d     = overflow_q  | (bus.wren & full_q);
    underflow_d    = underflow_q | (bus.rden & empty_q);
    rdvalid_d      = rd_acc;
    rddata_d       = rd_acc ? mem[rd_ptr_q] : rddata_q;
  end

  always_ff @(posedge memclk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= AF_RST;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      rdvalid_q      <= 1'b0;
      rddata_q       <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      rdvalid_q      <= rdvalid_d;
      rddata_q       <= rddata_d;
    end
  end

  // Storage is not reset; writes during reset are dropped.
  always_ff @(posedge memclk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= bus.wrdata;
  end

  assign bus.rddata       = rddata_q;
  assign bus.rdvalid      = rdvalid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
